// File: rtl/sensor_scan_pkg.sv
// Shared types and constants for the baggage-drop height sensor scan sequencer.
package sensor_scan_pkg;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        GAP,
        CALC,
        DONE
    } state_t;

    localparam int NUM_SENSORS = 4;
    localparam int IDX_W       = 2;
    localparam int SUM_W       = 10;

endpackage

// File: rtl/sensor_scan_ctrl_height_calc.sv
// Combinational height rule: pairwise ceil-average when a sensor reads zero,
// otherwise ceil of half of the floor-halved four-sensor sum.
module height_calc
    import sensor_scan_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] r1,
    input  logic [DATA_W-1:0] r2,
    input  logic [DATA_W-1:0] r3,
    input  logic [DATA_W-1:0] r4,
    output logic [DATA_W-1:0] h
);

    logic [SUM_W-1:0] sum_ac;
    logic [SUM_W-1:0] sum_bd;
    logic [SUM_W-1:0] sum_all;
    logic [SUM_W-1:0] half_all;

    assign sum_ac   = SUM_W'(r1) + SUM_W'(r3);
    assign sum_bd   = SUM_W'(r2) + SUM_W'(r4);
    assign sum_all  = sum_ac + sum_bd;
    assign half_all = sum_all >> 1;

    // Later rules deliberately override earlier ones.
    always_comb begin
        h = '0;
        if (r1 == '0 || r3 == '0) begin
            h = DATA_W'((sum_bd + SUM_W'(1)) >> 1);
        end
        if (r2 == '0 || r4 == '0) begin
            h = DATA_W'((sum_ac + SUM_W'(1)) >> 1);
        end
        if (r1 != '0 && r2 != '0 && r3 != '0 && r4 != '0) begin
            h = DATA_W'((half_all + SUM_W'(1)) >> 1);
        end
    end

endmodule

// File: rtl/sensor_scan_ctrl.sv
// Polls four height sensors over a shared req/ack bus with per-sensor timeout
// and publishes one registered height per scan with a one-cycle valid strobe.
module sensor_scan_ctrl
    import sensor_scan_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int DATA_W         = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   sens_ack,
    input  logic [DATA_W-1:0]      sens_data,
    output logic                   sens_req,
    output logic [IDX_W-1:0]       sens_sel,
    output logic                   busy,
    output logic [DATA_W-1:0]      height,
    output logic                   height_valid,
    output logic [NUM_SENSORS-1:0] timeout_flags
);

    localparam int                 CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(NUM_SENSORS - 1);

    state_t                               state, state_nxt;
    logic [IDX_W-1:0]                     idx, idx_nxt;
    logic [CNT_W-1:0]                     counter, counter_nxt;
    logic [NUM_SENSORS-1:0][DATA_W-1:0]   readings, readings_nxt;
    logic [NUM_SENSORS-1:0]               flags_nxt;
    logic [DATA_W-1:0]                    height_nxt;
    logic [DATA_W-1:0]                    calc_h;
    logic                                 slot_done;

    height_calc #(
        .DATA_W (DATA_W)
    ) u_height_calc (
        .r1 (readings[0]),
        .r2 (readings[1]),
        .r3 (readings[2]),
        .r4 (readings[3]),
        .h  (calc_h)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            idx           <= '0;
            counter       <= '0;
            readings      <= '0;
            height        <= '0;
            timeout_flags <= '0;
        end else begin
            state         <= state_nxt;
            idx           <= idx_nxt;
            counter       <= counter_nxt;
            readings      <= readings_nxt;
            height        <= height_nxt;
            timeout_flags <= flags_nxt;
        end
    end

    // An ack in the final timeout cycle still counts as a real reading.
    always_comb begin
        state_nxt    = state;
        idx_nxt      = idx;
        counter_nxt  = counter;
        readings_nxt = readings;
        flags_nxt    = timeout_flags;
        height_nxt   = height;
        slot_done    = 1'b0;

        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt   = REQ;
                    idx_nxt     = '0;
                    counter_nxt = '0;
                    flags_nxt   = '0;
                end
            end
            REQ: begin
                counter_nxt = counter + CNT_W'(1);
                if (sens_ack) begin
                    readings_nxt[idx] = sens_data;
                    slot_done         = 1'b1;
                end else if (counter == CNT_LAST) begin
                    readings_nxt[idx] = '0;
                    flags_nxt[idx]    = 1'b1;
                    slot_done         = 1'b1;
                end
                if (slot_done) begin
                    state_nxt = (idx == IDX_LAST) ? CALC : GAP;
                end
            end
            GAP: begin
                idx_nxt     = idx + IDX_W'(1);
                counter_nxt = '0;
                state_nxt   = REQ;
            end
            CALC: begin
                height_nxt = calc_h;
                state_nxt  = DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign sens_req     = (state == REQ);
    assign sens_sel     = idx;
    assign busy         = (state != IDLE);
    assign height_valid = (state == DONE);

endmodule

// File: tb/tb_sensor_scan_ctrl.sv
// Directed bench for sensor_scan_ctrl: table of full scans plus hand-written
// reset-abort and start-while-busy sequences, and a standalone height_calc table.
module tb_sensor_scan_ctrl;

    localparam int T = 16;

    typedef struct {
        logic [7:0] r1, r2, r3, r4;
        logic [3:0] noack;
        logic [7:0] exp_h;
        logic [3:0] exp_flags;
        int         exp_lat;
    } scan_vec_t;

    typedef struct {
        logic [7:0] r1, r2, r3, r4;
        logic [7:0] exp_h;
    } calc_vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       sens_ack = 1'b0;
    logic [7:0] sens_data = 8'h00;
    logic       sens_req;
    logic [1:0] sens_sel;
    logic       busy;
    logic [7:0] height;
    logic       height_valid;
    logic [3:0] timeout_flags;

    logic [3:0][7:0] rdg = '0;
    logic [3:0]      noack_mask = '0;

    logic [7:0] c_r1 = '0, c_r2 = '0, c_r3 = '0, c_r4 = '0;
    logic [7:0] c_h;

    int nvec = 0;
    int nerr = 0;

    scan_vec_t vecs[$];
    calc_vec_t cvecs[$];

    sensor_scan_ctrl #(
        .TIMEOUT_CYCLES (T),
        .DATA_W         (8)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .sens_ack      (sens_ack),
        .sens_data     (sens_data),
        .sens_req      (sens_req),
        .sens_sel      (sens_sel),
        .busy          (busy),
        .height        (height),
        .height_valid  (height_valid),
        .timeout_flags (timeout_flags)
    );

    height_calc #(.DATA_W(8)) u_calc (
        .r1 (c_r1), .r2 (c_r2), .r3 (c_r3), .r4 (c_r4), .h (c_h)
    );

    always #5 clk = ~clk;

    // Sensor model: acks on the first REQ cycle unless masked; junk data otherwise.
    always @(negedge clk) begin
        if (sens_req && !noack_mask[sens_sel]) begin
            sens_ack  = 1'b1;
            sens_data = rdg[sens_sel];
        end else begin
            sens_ack  = 1'b0;
            sens_data = 8'hA5;
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nvec++;
        if (actual !== expected) begin
            nerr++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic pulseStart();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic applyStimulus(input scan_vec_t v, output int lat);
        rdg        = {v.r4, v.r3, v.r2, v.r1};
        noack_mask = v.noack;
        pulseStart();
        lat = 0;
        for (int k = 1; k <= 300; k++) begin
            @(posedge clk);
            #1;
            if (height_valid) begin
                lat = k + 1;
                break;
            end
        end
    endtask

    task automatic addVec(input logic [7:0] a, b, c, d, input logic [3:0] na,
                          input logic [7:0] h, input logic [3:0] fl, input int lat);
        scan_vec_t v;
        v.r1 = a; v.r2 = b; v.r3 = c; v.r4 = d;
        v.noack = na; v.exp_h = h; v.exp_flags = fl; v.exp_lat = lat;
        vecs.push_back(v);
    endtask

    task automatic addCalc(input logic [7:0] a, b, c, d, input logic [7:0] h);
        calc_vec_t v;
        v.r1 = a; v.r2 = b; v.r3 = c; v.r4 = d; v.exp_h = h;
        cvecs.push_back(v);
    endtask

    initial begin
        int lat;
        int nv;
        bit dchk;

        addVec(8'd140, 8'd138, 8'd139, 8'd140, 4'b0000, 8'd139, 4'b0000, 9);
        addVec(8'd0,   8'd140, 8'd139, 8'd139, 4'b0000, 8'd140, 4'b0000, 9);
        addVec(8'd0,   8'd0,   8'd100, 8'd7,   4'b0000, 8'd50,  4'b0000, 9);
        addVec(8'd120, 8'd120, 8'd120, 8'd120, 4'b0100, 8'd120, 4'b0100, 9 + (T - 1));
        addVec(8'd255, 8'd255, 8'd255, 8'd255, 4'b0000, 8'd255, 4'b0000, 9);
        addVec(8'd10,  8'd20,  8'd30,  8'd41,  4'b0000, 8'd25,  4'b0000, 9);
        addVec(8'd1,   8'd0,   8'd0,   8'd0,   4'b0000, 8'd1,   4'b0000, 9);
        addVec(8'd9,   8'd9,   8'd9,   8'd9,   4'b1111, 8'd0,   4'b1111, 9 + 4 * (T - 1));

        addCalc(8'd0,   8'd0,   8'd0,   8'd0,   8'd0);
        addCalc(8'd255, 8'd255, 8'd255, 8'd255, 8'd255);
        addCalc(8'd0,   8'd255, 8'd0,   8'd255, 8'd255);
        addCalc(8'd255, 8'd0,   8'd254, 8'd0,   8'd255);
        addCalc(8'd1,   8'd1,   8'd1,   8'd1,   8'd1);
        addCalc(8'd1,   8'd2,   8'd1,   8'd1,   8'd1);
        addCalc(8'd3,   8'd3,   8'd3,   8'd3,   8'd3);
        addCalc(8'd0,   8'd1,   8'd0,   8'd2,   8'd2);
        addCalc(8'd5,   8'd0,   8'd0,   8'd9,   8'd3);

        // Reset state
        #12;
        checkOutput("rst_sens_req", sens_req, 0);
        checkOutput("rst_sens_sel", sens_sel, 0);
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_height", height, 0);
        checkOutput("rst_height_valid", height_valid, 0);
        checkOutput("rst_timeout_flags", timeout_flags, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Standalone height rule table
        foreach (cvecs[i]) begin
            c_r1 = cvecs[i].r1; c_r2 = cvecs[i].r2; c_r3 = cvecs[i].r3; c_r4 = cvecs[i].r4;
            #1;
            checkOutput($sformatf("calc_h[%0d]", i), c_h, cvecs[i].exp_h);
        end

        // Reset during REQ of sensor index 1 aborts without a result
        rdg = {8'd77, 8'd77, 8'd77, 8'd77};
        noack_mask = 4'b0000;
        pulseStart();
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("abort_req_before", sens_req, 1);
        checkOutput("abort_sel_before", sens_sel, 1);
        rst_n = 1'b0;
        #1;
        checkOutput("abort_sens_req", sens_req, 0);
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_sel", sens_sel, 0);
        @(negedge clk);
        rst_n = 1'b1;
        nv = 0;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (height_valid) nv++;
        end
        checkOutput("abort_no_valid", nv, 0);
        checkOutput("abort_height", height, 0);

        // Table of complete scans
        foreach (vecs[i]) begin
            applyStimulus(vecs[i], lat);
            checkOutput($sformatf("latency[%0d]", i), lat, vecs[i].exp_lat);
            checkOutput($sformatf("height[%0d]", i), height, vecs[i].exp_h);
            checkOutput($sformatf("flags[%0d]", i), timeout_flags, vecs[i].exp_flags);
            @(posedge clk); #1;
            checkOutput($sformatf("valid_drop[%0d]", i), height_valid, 0);
            checkOutput($sformatf("idle_busy[%0d]", i), busy, 0);
            checkOutput($sformatf("height_hold[%0d]", i), height, vecs[i].exp_h);
        end

        // Start during REQ and during DONE are both ignored
        rdg = {8'd255, 8'd255, 8'd255, 8'd255};
        noack_mask = 4'b0000;
        pulseStart();
        @(posedge clk); #1;
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        nv = 0;
        dchk = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(posedge clk); #1;
            if (dchk) begin
                start = 1'b0;
                checkOutput("start_in_done_busy", busy, 0);
                dchk = 1'b0;
            end
            if (height_valid) begin
                nv++;
                checkOutput("busy_h255", height, 255);
                start = 1'b1;
                dchk = 1'b1;
            end
        end
        start = 1'b0;
        checkOutput("single_valid", nv, 1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
